jmp_ras_unit: RTL

- Parametrised successor to the execution-unit jump stage: computes aligned jump targets for JMP/JSR/JSR_COROUTINE/RET and the link value for JSR.
- Adds a return-address stack (RAS) that predicts RET targets and flags mispredictions.
- Adds a one-entry valid/ready output register, so the block can stall against writeback.
- Sits in the EXU beside the integer ALU. Its outputs go to the register writeback (res_data) and to fetch redirect (res_adr, mispredict).

---
 rtl/jmp_pkg.sv | 16 +
 rtl/jmp_ras_unit_if.sv | 29 ++
 rtl/jmp_ras.sv | 54 +++++
 rtl/jmp_ras_unit.sv | 102 ++++++++++
 4 files changed

// File: rtl/jmp_pkg.sv
// Shared function codes and default widths for the jump/return-address-stack unit.
package jmp_pkg;

  localparam int DEF_DW        = 32;
  localparam int DEF_ALIGN     = 2;
  localparam int DEF_RAS_DEPTH = 8;
  localparam int DEF_FCT_W     = 3;

  typedef enum logic [2:0] {
    JMP           = 3'd0,
    JSR           = 3'd1,
    JSR_COROUTINE = 3'd2,
    RET           = 3'd3
  } fct_e;

endpackage

// File: rtl/jmp_ras_unit_if.sv
// Operation-in / result-out handshake bundle between the EXU issue side and the jump unit.
interface jmp_ras_unit_if
  import jmp_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int FCT_W = DEF_FCT_W
);
  logic             in_valid;
  logic             in_ready;
  logic [FCT_W-1:0] fct;
  logic [DW-1:0]    op1;
  logic [DW-1:0]    op2;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    res_data;
  logic [DW-1:0]    res_adr;
  logic             mispredict;
  logic             ras_empty;

  modport master (
    output in_valid, fct, op1, op2, out_ready,
    input  in_ready, out_valid, res_data, res_adr, mispredict, ras_empty
  );

  modport slave (
    input  in_valid, fct, op1, op2, out_ready,
    output in_ready, out_valid, res_data, res_adr, mispredict, ras_empty
  );
endinterface

// File: rtl/jmp_ras.sv
// Circular return-address stack; push at full overwrites the oldest entry, pop on empty is ignored.
// Updates take effect on the next clock edge; flush wins over any push/pop/replace.
module jmp_ras #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic          replace,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] top,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] topPtr;
  logic [PW:0]   count;
  logic          doPush;
  logic          doPop;
  logic          doRepl;

  assign empty  = (count == '0);
  assign top    = mem[topPtr];
  // Replacing the top of an empty stack degenerates into a push.
  assign doPush = !flush && (push || (replace && empty));
  assign doRepl = !flush && replace && !empty;
  assign doPop  = !flush && pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      topPtr <= '0;
      count  <= '0;
    end else if (flush) begin
      topPtr <= '0;
      count  <= '0;
    end else if (doPush) begin
      topPtr <= topPtr + PW'(1);
      if (count != (PW+1)'(DEPTH)) count <= count + (PW+1)'(1);
    end else if (doPop) begin
      topPtr <= topPtr - PW'(1);
      count  <= count - (PW+1)'(1);
    end
  end

  // Entries are never reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (doPush)      mem[topPtr + PW'(1)] <= din;
    else if (doRepl) mem[topPtr]          <= din;
  end
endmodule

// File: rtl/jmp_ras_unit.sv
// Jump target / link computation with RET prediction via a return-address stack; latency 1.
// One-entry output register: in_ready drops only while a result is held and out_ready is low.
module jmp_ras_unit
  import jmp_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int ALIGN     = DEF_ALIGN,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH,
  parameter int FCT_W     = DEF_FCT_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  jmp_ras_unit_if.slave  bus
);
  localparam logic [DW-1:0] ALIGN_MASK = ~((DW'(1) << ALIGN) - DW'(1));

  logic          outValid;
  logic [DW-1:0] resData;
  logic [DW-1:0] resAdr;
  logic          resMisp;
  logic          inReady;
  logic          accept;
  logic [DW-1:0] tgt;
  logic [DW-1:0] rasTop;
  logic          rasEmpty;
  logic          rasPush;
  logic          rasPop;
  logic          rasRepl;
  logic [DW-1:0] nxtData;
  logic [DW-1:0] nxtAdr;
  logic          nxtMisp;

  assign inReady = !outValid || bus.out_ready;
  assign accept  = bus.in_valid && inReady;
  assign tgt     = bus.op2 & ALIGN_MASK;

  always_comb begin
    nxtData = '0;
    nxtAdr  = '0;
    nxtMisp = 1'b0;
    rasPush = 1'b0;
    rasPop  = 1'b0;
    rasRepl = 1'b0;
    case (bus.fct)
      FCT_W'(JMP): nxtAdr = tgt;
      FCT_W'(JSR): begin
        nxtAdr  = tgt;
        nxtData = bus.op1;
        rasPush = accept;
      end
      FCT_W'(JSR_COROUTINE): begin
        nxtAdr  = tgt;
        nxtData = bus.op1;
        rasRepl = accept;
      end
      FCT_W'(RET): begin
        nxtAdr  = tgt;
        nxtMisp = rasEmpty || (rasTop != tgt);
        rasPop  = accept;
      end
      default: ;
    endcase
  end

  jmp_ras #(.DW(DW), .DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (rasPush),
    .pop     (rasPop),
    .replace (rasRepl),
    .din     (bus.op1),
    .top     (rasTop),
    .empty   (rasEmpty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid <= 1'b0;
      resData  <= '0;
      resAdr   <= '0;
      resMisp  <= 1'b0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (accept) begin
      outValid <= 1'b1;
      resData  <= nxtData;
      resAdr   <= nxtAdr;
      resMisp  <= nxtMisp;
    end else if (bus.out_ready) begin
      outValid <= 1'b0;
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.out_valid  = outValid;
  assign bus.res_data   = resData;
  assign bus.res_adr    = resAdr;
  assign bus.mispredict = resMisp;
  assign bus.ras_empty  = rasEmpty;
endmodule
